// File: rtl/tetris_pkg.sv
// Shared types and constants for the falling-piece controller.
// Used by tetromino_ctrl and edge_latch.
package tetris_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      FALL = 1'b1
   } state_e;

   typedef enum logic [2:0] {
      PIECE_I = 3'd0,
      PIECE_O = 3'd1,
      PIECE_T = 3'd2,
      PIECE_S = 3'd3,
      PIECE_Z = 3'd4,
      PIECE_J = 3'd5,
      PIECE_L = 3'd6
   } piece_e;

   localparam int unsigned CELL        = 8;
   localparam int unsigned SPRITE_SIZE = 32;

   // ctrl word layout: {type[2:0], rot[1:0]}
   localparam int unsigned TYPE_MSB = 4;
   localparam int unsigned TYPE_LSB = 2;
   localparam int unsigned ROT_MSB  = 1;
   localparam int unsigned CTRL_W   = TYPE_MSB + 1;

   // Map a raw 3-bit type onto a legal piece; 7 folds back to I.
   function automatic logic [2:0] legal_type(input logic [2:0] raw);
      return (raw == 3'd7) ? 3'(PIECE_I) : raw;
   endfunction

endpackage

// File: rtl/edge_latch.sv
// Rising-edge detector with a sticky pending flag and synchronous clear.
// A new edge in the clearing cycle wins, so no press is lost.
module edge_latch (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_i,
   input  logic clr_i,
   output logic flag_o
);

   logic btn_q;
   logic flag_q, flag_d;
   logic rise;

   assign rise   = btn_i & ~btn_q;
   assign flag_d = rise | (flag_q & ~clr_i);
   assign flag_o = flag_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         btn_q  <= 1'b0;
         flag_q <= 1'b0;
      end else begin
         btn_q  <= btn_i;
         flag_q <= flag_d;
      end
   end

endmodule

// File: rtl/tetromino_ctrl.sv
// Falling-piece controller: spawn, move, rotate, gravity, soft-drop, landing.
// Optional held-button auto-repeat is enabled by defining AUTO_REPEAT_EN.
module tetromino_ctrl
   import tetris_pkg::*;
#(
   parameter int unsigned FIELD_X0    = 280,
   parameter int unsigned FIELD_Y0    = 80,
   parameter int unsigned FIELD_W     = 80,
   parameter int unsigned FIELD_H     = 160,
   parameter int unsigned GRAV_FRAMES = 30
`ifdef AUTO_REPEAT_EN
   ,
   parameter int unsigned REPEAT_FRAMES = 6
`endif
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              frame_tick,
   input  logic              spawn,
   input  logic [2:0]        piece_type,
   input  logic              btn_left,
   input  logic              btn_right,
   input  logic              btn_rot,
   input  logic              btn_drop,
   output logic [10:0]       x0,
   output logic [10:0]       y0,
   output logic [CTRL_W-1:0] ctrl,
   output logic              active,
   output logic              landed
);

   localparam int unsigned PW = 12;
   localparam int unsigned OW = 11;
   localparam int unsigned GW = (GRAV_FRAMES > 1) ? $clog2(GRAV_FRAMES) : 1;

   localparam logic [PW-1:0] X_MIN   = PW'(FIELD_X0);
   localparam logic [PW-1:0] X_MAX   = PW'(FIELD_X0 + FIELD_W - SPRITE_SIZE);
   localparam logic [PW-1:0] Y_MIN   = PW'(FIELD_Y0);
   localparam logic [PW-1:0] Y_MAX   = PW'(FIELD_Y0 + FIELD_H - SPRITE_SIZE);
   localparam logic [PW-1:0] X_SPAWN =
      PW'(FIELD_X0 + (((FIELD_W - SPRITE_SIZE) / 2) / CELL) * CELL);
   localparam logic [PW-1:0] STEP    = PW'(CELL);
   localparam logic [GW-1:0] G_LAST  = GW'(GRAV_FRAMES - 1);

   state_e          state_q, state_d;
   logic [OW-1:0]   x_q, x_d;
   logic [OW-1:0]   y_q, y_d;
   logic [2:0]      type_q, type_d;
   logic [1:0]      rot_q, rot_d;
   logic [GW-1:0]   gcnt_q, gcnt_d;
   logic            landed_q, landed_d;

   logic            flag_clr;
   logic            pend_l, pend_r, pend_rot;
   logic            rep_l, rep_r;
   logic            go_l, go_r;

   logic [PW-1:0]   x_ext, y_ext;
   logic [PW-1:0]   x_left, x_right, y_next;
   logic            grav_due, fits;

   // Button edge capture
   edge_latch u_lat_left (
      .clk     (clk),
      .reset_n (reset_n),
      .btn_i   (btn_left),
      .clr_i   (flag_clr),
      .flag_o  (pend_l)
   );

   edge_latch u_lat_right (
      .clk     (clk),
      .reset_n (reset_n),
      .btn_i   (btn_right),
      .clr_i   (flag_clr),
      .flag_o  (pend_r)
   );

   edge_latch u_lat_rot (
      .clk     (clk),
      .reset_n (reset_n),
      .btn_i   (btn_rot),
      .clr_i   (flag_clr),
      .flag_o  (pend_rot)
   );

`ifdef AUTO_REPEAT_EN
   localparam int unsigned RW = $clog2(2 * REPEAT_FRAMES + 1);
   localparam logic [RW-1:0] R_ONE  = RW'(REPEAT_FRAMES);
   localparam logic [RW-1:0] R_FIRE = RW'(2 * REPEAT_FRAMES);

   logic [1:0]    hdir_q, hdir_d;
   logic [RW-1:0] rcnt_q, rcnt_d;
   logic [RW-1:0] rcnt_base, rcnt_inc;
   logic          rep_fire;

   // Held direction: bit0 left only, bit1 right only, zero when none or both.
   assign hdir_d    = {btn_right & ~btn_left, btn_left & ~btn_right};
   assign rcnt_base = ((hdir_d != hdir_q) || (hdir_d == 2'b00)) ? '0 : rcnt_q;
   assign rcnt_inc  = rcnt_base + RW'(1);

   always_comb begin
      rcnt_d   = rcnt_base;
      rep_fire = 1'b0;
      if (frame_tick && (hdir_d != 2'b00)) begin
         if (rcnt_inc == R_FIRE) begin
            rep_fire = 1'b1;
            rcnt_d   = R_ONE;
         end else begin
            rcnt_d   = rcnt_inc;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hdir_q <= 2'b00;
         rcnt_q <= '0;
      end else begin
         hdir_q <= hdir_d;
         rcnt_q <= rcnt_d;
      end
   end

   assign rep_l = rep_fire & hdir_d[0];
   assign rep_r = rep_fire & hdir_d[1];
`else
   assign rep_l = 1'b0;
   assign rep_r = 1'b0;
`endif

   assign go_l = pend_l | rep_l;
   assign go_r = pend_r | rep_r;

   // Clamped position arithmetic, widened to avoid wrap at the bounds
   assign x_ext    = {1'b0, x_q};
   assign y_ext    = {1'b0, y_q};
   assign x_left   = (x_ext >= X_MIN + STEP) ? (x_ext - STEP) : X_MIN;
   assign x_right  = (x_ext + STEP > X_MAX) ? X_MAX : (x_ext + STEP);
   assign y_next   = y_ext + STEP;
   assign fits     = (y_next <= Y_MAX);
   assign grav_due = btn_drop | (gcnt_q == G_LAST);

   // Next-state and datapath updates
   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      type_d   = type_q;
      rot_d    = rot_q;
      gcnt_d   = gcnt_q;
      landed_d = 1'b0;
      flag_clr = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (spawn) begin
               x_d      = OW'(X_SPAWN);
               y_d      = OW'(Y_MIN);
               type_d   = legal_type(piece_type);
               rot_d    = 2'd0;
               gcnt_d   = '0;
               flag_clr = 1'b1;
               state_d  = FALL;
            end
         end

         FALL: begin
            if (frame_tick) begin
               flag_clr = 1'b1;
               if (grav_due && !fits) begin
                  landed_d = 1'b1;
                  state_d  = IDLE;
               end else begin
                  if (pend_rot) begin
                     rot_d = rot_q + 2'd1;
                  end
                  if (go_l && !go_r) begin
                     x_d = OW'(x_left);
                  end else if (go_r && !go_l) begin
                     x_d = OW'(x_right);
                  end
                  if (grav_due) begin
                     y_d    = OW'(y_next);
                     gcnt_d = '0;
                  end else begin
                     gcnt_d = gcnt_q + GW'(1);
                  end
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         x_q      <= OW'(X_MIN);
         y_q      <= OW'(Y_MIN);
         type_q   <= 3'd0;
         rot_q    <= 2'd0;
         gcnt_q   <= '0;
         landed_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         type_q   <= type_d;
         rot_q    <= rot_d;
         gcnt_q   <= gcnt_d;
         landed_q <= landed_d;
      end
   end

   assign x0                      = x_q;
   assign y0                      = y_q;
   assign ctrl[TYPE_MSB:TYPE_LSB] = type_q;
   assign ctrl[ROT_MSB:0]         = rot_q;
   assign active                  = (state_q == FALL);
   assign landed                  = landed_q;

endmodule

// File: doc/tetromino_ctrl.md
Name: tetromino_ctrl

Overview:
- Falling-piece controller directly upstream of the block sprite source.
- Produces the sprite origin (x0, y0) and the 5-bit ctrl word (type in [4:2], rotation in [1:0]) consumed by the sprite renderer.
- Turns debounced buttons and a per-frame tick into left/right moves, rotation, gravity and soft-drop, clamped to the playfield bounding box.
- Position updates occur only on frame_tick, so the rendered sprite never tears mid-frame.

Parameters:
- FIELD_X0, 280, left pixel edge of playfield
- FIELD_Y0, 80, top pixel edge of playfield
- FIELD_W, 80, playfield width in pixels (10 cells)
- FIELD_H, 160, playfield height in pixels (20 cells)
- CELL, 8, pixel step per move/gravity step (32x32 sprite = 4x4 cells)
- GRAV_FRAMES, 30, frame_ticks per gravity step
- REPEAT_FRAMES, 6, auto-repeat period in frames (optional feature only)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse per video frame (start of vertical blank)
- spawn  in  1  one-cycle request to start a new piece
- piece_type  in  3  type for spawn (0=I … 6=L; 7 treated as 0)
- btn_left, btn_right, btn_rot, btn_drop  in  1 each  debounced levels
- x0, y0  out  11 each  sprite origin, registered
- ctrl  out  5  {type[2:0], rot[1:0]}, registered
- active  out  1  piece is falling
- landed  out  1  one-cycle pulse when piece comes to rest

Behaviour:
- Reset (async, reset_n=0): state IDLE, x0=FIELD_X0, y0=FIELD_Y0, ctrl=0, active=0, landed=0, gravity counter=0, pending flags cleared.
- Derived constants: X_MIN=FIELD_X0, X_MAX=FIELD_X0+FIELD_W-32, Y_MAX=FIELD_Y0+FIELD_H-32, X_SPAWN=FIELD_X0+((FIELD_W-32)/2 rounded down to a CELL multiple). Defaults: 280, 328, 208, 304.
- Edge capture: rising edges of btn_left, btn_right and btn_rot set sticky pending flags in any cycle. Flags clear on the frame_tick that consumes them.
- IDLE:
  - spawn=1 loads x0=X_SPAWN, y0=FIELD_Y0, ctrl={piece_type,2'b00}, clears pending flags and gravity counter, sets active=1, then goes to FALL. Outputs are visible the next cycle.
  - In IDLE, frame_tick and buttons are ignored, except that button edges still set pending flags; spawn clears them.
- FALL, on frame_tick (all updates register in that same cycle; visible next cycle). Apply in order:
  1. Rotate: if rot pending, rot ← rot+1 mod 4 (3→0 wraps).
  2. Horizontal: left-only pending gives x0 ← max(x0−CELL, X_MIN); right-only gives x0 ← min(x0+CELL, X_MAX); both pending gives no move.
  3. Gravity: a step is due when btn_drop=1 or the counter has reached GRAV_FRAMES−1; otherwise the counter increments.
     - If a step is due and y0+CELL ≤ Y_MAX: y0 ← y0+CELL and the counter ← 0.
     - If a step is due and y0+CELL > Y_MAX: landed=1 for one cycle, active ← 0, state → IDLE, x0/y0/ctrl hold their values.
- spawn during FALL is ignored.
- frame_tick and spawn in the same IDLE cycle: spawn wins; that tick is not applied.
- Arithmetic: unsigned, 12-bit internally to avoid overflow at the bounds; outputs are 11 bits.
- A mid-operation reset returns to the reset state immediately; no landed pulse is emitted.

Optional Feature:
- Macro AUTO_REPEAT_EN.
- With it: while btn_left or btn_right has been held for 2·REPEAT_FRAMES frame_ticks, a synthetic pending flag is set every REPEAT_FRAMES ticks. One repeat counter is shared and resets when the held direction changes or is released.
- Without it: one move per rising edge only; no repeat counter is synthesised.

Decomposition:
- tetris_pkg:
  - state enum {IDLE, FALL}
  - piece_t enum (I,O,T,S,Z,J,L)
  - CELL and SPRITE_SIZE=32 constants
  - ctrl field positions (TYPE_MSB=4, TYPE_LSB=2, ROT_MSB=1)
- Sub-module edge_latch: rising-edge detect plus sticky flag with synchronous clear. Instantiated three times (left, right, rot).

Test Plan:
- Reset, then spawn with piece_type=2 → next cycle x0=304, y0=80, ctrl=5'b01000, active=1.
- Hold no buttons for 30 frame_ticks → y0 goes 80→88 on the 30th tick; counter restarts.
- Pulse btn_left 4 times, one per frame → x0 304→296→288→280→280 (clamped). Right from 328 stays 328.
- btn_rot pulsed 5 times across frames → rot goes 1,2,3,0,1; btn_left and btn_right edges in the same frame → x0 unchanged.
- Hold btn_drop from y0=80 → y0 reaches 208 after 16 ticks. On the 17th tick: landed=1 for exactly one cycle, active=0, y0 stays 208, a later spawn is accepted.
- Assert reset_n=0 mid-fall at y0=144 → outputs return to reset values asynchronously with no landed pulse. With AUTO_REPEAT_EN, holding btn_right for 18 ticks from x0=304 → moves on ticks 1, 12 and 18 → x0=328.
